// File: rtl/gb_cart_pkg.sv
// Shared types and cartridge memory-map constants for the Game Boy cartridge bus master.
// Pure declarations: no logic, no latency, no flow control.
package gb_cart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [15:0] ROM_END   = 16'h7FFF;
  localparam logic [15:0] ERAM_BASE = 16'hA000;
  localparam logic [15:0] ERAM_END  = 16'hBFFF;
  localparam logic [7:0]  OPEN_BUS  = 8'hFF;

endpackage

// File: rtl/cart_addr_decode.sv
// Classifies a CPU address as ROM, external RAM or outside cartridge space.
// Purely combinational, zero latency, no flow control.
module cart_addr_decode
  import gb_cart_pkg::*;
(
  input  logic [15:0] addr_i,
  output logic        in_cart_o,
  output logic        is_eram_o
);

  assign is_eram_o = (addr_i >= ERAM_BASE) && (addr_i <= ERAM_END);
  assign in_cart_o = (addr_i <= ROM_END) || is_eram_o;

endmodule

// File: rtl/cart_bus_master.sv
// Turns one CPU request at a time into a timed cartridge read/write strobe sequence.
// Response READ_WAIT+1 / WR_PULSE+1 cycles after accept (1 if outside cart); accepts only in IDLE, response has no backpressure.
module cart_bus_master
  import gb_cart_pkg::*;
#(
  parameter int unsigned READ_WAIT = 2,
  parameter int unsigned WR_PULSE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_DATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DATA,
  output logic [15:0] CART_ADDR,
  output logic [7:0]  CART_DATA_out,
  input  logic [7:0]  CART_DATA_in,
  output logic        CART_RD,
  output logic        CART_WR,
  output logic        CART_CS
);

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        eram_q, eram_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  rsp_q, rsp_d;
  logic        dec_in_cart;
  logic        dec_eram;

  cart_addr_decode u_decode (
    .addr_i    (REQ_ADDR),
    .in_cart_o (dec_in_cart),
    .is_eram_o (dec_eram)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    eram_d  = eram_q;
    data_d  = data_q;
    addr_d  = addr_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          wr_d   = REQ_WR;
          data_d = REQ_DATA;
          eram_d = dec_eram;
          cnt_d  = REQ_WR ? WR_LOAD : RD_LOAD;
          // The cartridge address bus only moves for accesses that actually reach the cartridge.
          if (dec_in_cart) begin
            state_d = ACCESS;
            addr_d  = REQ_ADDR;
          end else begin
            state_d = DONE;
            rsp_d   = OPEN_BUS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          rsp_d   = wr_q ? data_q : CART_DATA_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      eram_q  <= 1'b0;
      data_q  <= OPEN_BUS;
      addr_q  <= 16'h0000;
      rsp_q   <= OPEN_BUS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      eram_q  <= eram_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rsp_q   <= rsp_d;
    end
  end

  assign REQ_READY     = (state_q == IDLE);
  assign RSP_VALID     = (state_q == DONE);
  assign RSP_DATA      = rsp_q;
  assign CART_ADDR     = addr_q;
  assign CART_RD       = (state_q == ACCESS) && !wr_q;
  assign CART_WR       = (state_q == ACCESS) && wr_q;
  assign CART_CS       = (state_q == ACCESS) && eram_q;
  assign CART_DATA_out = ((state_q == ACCESS) && wr_q) ? data_q : OPEN_BUS;

endmodule

// File: tb/tb_cart_bus_master.sv
// Randomized bench for cart_bus_master: driver pushes expected completions, monitor checks bus and responses each cycle.
module tb_cart_bus_master;

  localparam int RW = 2;
  localparam int WP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        REQ_VALID, REQ_READY, REQ_WR;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_DATA;
  logic        RSP_VALID;
  logic [7:0]  RSP_DATA;
  logic [15:0] CART_ADDR;
  logic [7:0]  CART_DATA_out, CART_DATA_in;
  logic        CART_RD, CART_WR, CART_CS;

  always #5 clk = ~clk;

  cart_bus_master #(.READ_WAIT(RW), .WR_PULSE(WP)) dut (
    .clk           (clk),
    .rst           (rst),
    .REQ_VALID     (REQ_VALID),
    .REQ_READY     (REQ_READY),
    .REQ_WR        (REQ_WR),
    .REQ_ADDR      (REQ_ADDR),
    .REQ_DATA      (REQ_DATA),
    .RSP_VALID     (RSP_VALID),
    .RSP_DATA      (RSP_DATA),
    .CART_ADDR     (CART_ADDR),
    .CART_DATA_out (CART_DATA_out),
    .CART_DATA_in  (CART_DATA_in),
    .CART_RD       (CART_RD),
    .CART_WR       (CART_WR),
    .CART_CS       (CART_CS)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  // Model of the transaction in flight: cycle 1 after accept is act_start, response in cycle act_len.
  bit          act_v = 1'b0;
  int          act_start = 0;
  int          act_len = 0;
  bit          act_wr, act_cart, act_eram;
  logic [15:0] act_addr;
  logic [7:0]  act_data;
  logic [15:0] last_addr = 16'h0000;
  bit          chk_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: per-cycle bus/handshake checks and scoreboard pop on every response pulse.
  initial begin
    logic [7:0] hold;
    bit   prst;
    int   k;
    bit   busy, bus, ev;
    exp_t e;
    hold = 8'hFF;
    prst = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (prst) hold = 8'hFF;
      prst = rst;
      if (chk_en && !rst) begin
        k    = cyc - act_start + 1;
        busy = act_v && (k >= 1) && (k <= act_len);
        bus  = busy && act_cart && (k < act_len);
        ev   = busy && (k == act_len);
        check("req_ready", 32'(REQ_READY), 32'(!busy));
        check("rsp_valid", 32'(RSP_VALID), 32'(ev));
        check("cart_rd", 32'(CART_RD), 32'(bus && !act_wr));
        check("cart_wr", 32'(CART_WR), 32'(bus && act_wr));
        check("cart_cs", 32'(CART_CS), 32'(bus && act_eram));
        check("cart_addr", 32'(CART_ADDR), 32'(bus ? act_addr : last_addr));
        check("cart_dout", 32'(CART_DATA_out), 32'((bus && act_wr) ? act_data : 8'hFF));
        if (RSP_VALID) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("rsp_data", 32'(RSP_DATA), 32'(e.data));
            check("rsp_cycle", cyc, e.due);
            hold = e.data;
          end
        end else begin
          check("rsp_hold", 32'(RSP_DATA), 32'(hold));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      CART_DATA_in = 8'($urandom);
    end
  endtask

  // Present a request, wait for accept, record the expectation; returns cycle 1 index in acc.
  task automatic send(input bit wr, input logic [15:0] a, input logic [7:0] d,
                      input logic [7:0] rb, input bit keep, output int acc);
    int   n;
    bit   cart, eram;
    int   len;
    exp_t e;
    REQ_VALID = 1'b1;
    REQ_WR    = wr;
    REQ_ADDR  = a;
    REQ_DATA  = d;
    n = 0;
    while (!REQ_READY && n < 64) begin
      @(negedge clk);
      CART_DATA_in = 8'($urandom);
      n++;
    end
    if (!REQ_READY) begin
      check("accept_timeout", 32'd0, 32'd1);
      REQ_VALID = 1'b0;
      acc = -1;
      return;
    end
    eram = (a >= 16'hA000) && (a <= 16'hBFFF);
    cart = (a <= 16'h7FFF) || eram;
    len  = !cart ? 1 : (wr ? WP + 1 : RW + 1);
    @(negedge clk);
    acc       = cyc;
    act_start = cyc;
    act_len   = len;
    act_wr    = wr;
    act_cart  = cart;
    act_eram  = eram;
    act_addr  = a;
    act_data  = d;
    act_v     = 1'b1;
    if (cart) last_addr = a;
    e.data = !cart ? 8'hFF : (wr ? d : rb);
    e.due  = cyc + len - 1;
    sb.push_back(e);
    if (!keep) begin
      REQ_VALID = 1'b0;
      REQ_WR    = 1'($urandom);
      REQ_ADDR  = 16'($urandom);
      REQ_DATA  = 8'($urandom);
    end
    CART_DATA_in = 8'($urandom);
    if (cart && !wr) begin
      repeat (RW - 1) @(negedge clk);
      CART_DATA_in = rb;
      @(negedge clk);
      CART_DATA_in = 8'($urandom);
    end
  endtask

  // Start a cartridge read and pulse reset in its first access cycle.
  task automatic send_abort(input logic [15:0] a);
    int   n;
    exp_t e;
    REQ_VALID = 1'b1;
    REQ_WR    = 1'b0;
    REQ_ADDR  = a;
    n = 0;
    while (!REQ_READY && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!REQ_READY) begin
      check("abort_accept_timeout", 32'd0, 32'd1);
      REQ_VALID = 1'b0;
      return;
    end
    @(negedge clk);
    act_start = cyc;
    act_len   = RW + 1;
    act_wr    = 1'b0;
    act_cart  = 1'b1;
    act_eram  = (a >= 16'hA000) && (a <= 16'hBFFF);
    act_addr  = a;
    act_data  = REQ_DATA;
    act_v     = 1'b1;
    last_addr = a;
    e.data = 8'h00;
    e.due  = cyc + RW;
    sb.push_back(e);
    REQ_VALID = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    act_v     = 1'b0;
    last_addr = 16'h0000;
    void'(sb.pop_back());
  endtask

  initial begin
    int          a1, a2;
    bit          wr, keep;
    logic [15:0] a;
    logic [15:0] bnd [6];
    bnd = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000};
    rst          = 1'b1;
    REQ_VALID    = 1'b0;
    REQ_WR       = 1'b0;
    REQ_ADDR     = 16'h0000;
    REQ_DATA     = 8'h00;
    CART_DATA_in = 8'h00;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    idle(2);

    send(1'b0, 16'h0134, 8'h00, 8'h54, 1'b0, a1); idle(2);
    send(1'b1, 16'h2000, 8'h05, 8'h00, 1'b0, a1); idle(2);
    send(1'b0, 16'hA010, 8'h00, 8'h3C, 1'b0, a1); idle(2);
    send(1'b0, 16'hC000, 8'h00, 8'h00, 1'b0, a1); idle(2);
    send(1'b0, 16'h0100, 8'h00, 8'h11, 1'b1, a1);
    send(1'b0, 16'h0101, 8'h00, 8'h22, 1'b0, a2);
    check("b2b_accept_gap", 32'(a2 - a1), 32'd4);
    idle(3);
    send_abort(16'h0150); idle(3);
    send(1'b1, 16'hBFFF, 8'hA5, 8'h00, 1'b0, a1);
    send(1'b1, 16'h7FFF, 8'h5A, 8'h00, 1'b0, a1);
    send(1'b1, 16'h8000, 8'h33, 8'h00, 1'b0, a1);
    send(1'b0, 16'h9FFF, 8'h00, 8'h44, 1'b0, a1);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'($urandom_range(0, 16'h7FFF));
        1:       a = 16'($urandom_range(16'hA000, 16'hBFFF));
        2:       a = 16'($urandom_range(16'h8000, 16'h9FFF));
        3:       a = 16'($urandom_range(16'hC000, 16'hFFFF));
        default: a = bnd[$urandom_range(0, 5)];
      endcase
      wr   = 1'($urandom);
      keep = ($urandom_range(0, 2) == 0);
      send(wr, a, 8'($urandom), 8'($urandom), keep, a1);
      if (!keep) idle($urandom_range(0, 2));
    end
    REQ_VALID = 1'b0;

    idle(10);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cart_bus_master.md
CART_BUS_MASTER -- requirements
Module: cart_bus_master

Interface
REQ-001 SHALL have parameter READ_WAIT, default 2, number of cycles CART_RD is held before data capture (legal 1..15).
REQ-002 SHALL have parameter WR_PULSE, default 1, number of cycles CART_WR is held (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports REQ_VALID input 1, REQ_READY output 1, REQ_WR input 1 (1=write, 0=read), REQ_ADDR input 16, REQ_DATA input 8, forming the CPU-side request channel.
REQ-006 SHALL have ports RSP_VALID output 1 and RSP_DATA output 8, forming the completion channel (read data or write acknowledge).
REQ-007 SHALL have ports CART_ADDR output 16, CART_DATA_out output 8, CART_DATA_in input 8, CART_RD output 1, CART_WR output 1, CART_CS output 1, forming the cartridge-side bus toward MBC1.

Function
REQ-008 SHALL use states IDLE, ACCESS, DONE; REQ_READY=1 only in IDLE.
REQ-009 SHALL accept a request on a posedge where REQ_VALID & REQ_READY, latching REQ_ADDR, REQ_DATA and REQ_WR.
REQ-010 SHALL decode cartridge space: ROM 0x0000-0x7FFF; external RAM 0xA000-0xBFFF; all other addresses are outside cartridge space.
REQ-011 For an outside-cartridge request, SHALL go IDLE->DONE with no bus activity; RSP_DATA=0xFF, RSP_VALID in cycle 1 after accept.
REQ-012 For a cartridge request, SHALL go IDLE->ACCESS, driving CART_ADDR=latched address from cycle 1 after accept.
REQ-013 CART_CS SHALL be 1 during ACCESS only when the address is in 0xA000-0xBFFF, otherwise 0.
REQ-014 Read: CART_RD=1 in cycles 1..READ_WAIT; CART_DATA_in SHALL be captured at the posedge ending cycle READ_WAIT; RSP_VALID=1 and RSP_DATA=captured byte in cycle READ_WAIT+1 (DONE).
REQ-015 Write: CART_WR=1 and CART_DATA_out=latched data in cycles 1..WR_PULSE; RSP_VALID=1 in cycle WR_PULSE+1 (DONE), RSP_DATA=latched write data.
REQ-016 CART_RD and CART_WR SHALL never be 1 in the same cycle.
REQ-017 A 4-bit down-counter SHALL load READ_WAIT-1 or WR_PULSE-1 on accept; ACCESS->DONE when it is 0, else decrement.
REQ-018 DONE SHALL last exactly one cycle, then IDLE; RSP_VALID is a single-cycle pulse with no backpressure.
REQ-019 Back-to-back requests SHALL be accepted no earlier than the cycle after DONE; REQ_VALID asserted in ACCESS/DONE is ignored until IDLE.
REQ-020 In IDLE and DONE, CART_RD=CART_WR=CART_CS=0, CART_ADDR holds its last value, CART_DATA_out=0xFF.
REQ-021 RSP_DATA SHALL hold its value outside RSP_VALID pulses.
REQ-022 Write to ROM space (0x0000-0x7FFF) SHALL be issued as a normal bus write (MBC1 register access), not suppressed.

Reset
REQ-023 rst SHALL force state IDLE, counter 0, REQ_READY=1, RSP_VALID=0, RSP_DATA=0xFF, CART_ADDR=0x0000, CART_DATA_out=0xFF, CART_RD=CART_WR=CART_CS=0.
REQ-024 rst asserted mid-ACCESS SHALL abort the access at the next posedge with no RSP_VALID issued for it; rst has priority over request accept.

Structure
REQ-025 Package gb_cart_pkg SHALL hold the state enum (IDLE/ACCESS/DONE) and region constants (ROM_END=0x7FFF, ERAM_BASE=0xA000, ERAM_END=0xBFFF, OPEN_BUS=0xFF).
REQ-026 Region decode SHALL be one combinational sub-module cart_addr_decode (in: 16-bit address; out: in_cart, is_eram).

Verification
REQ-027 Read 0x0134, READ_WAIT=2, CART_DATA_in=0x54 -> CART_RD=1 cycles 1-2, CS=0, RSP_VALID cycle 3 with RSP_DATA=0x54.
REQ-028 Write 0x2000 data 0x05, WR_PULSE=1 -> CART_WR=1 cycle 1 with CART_DATA_out=0x05, CS=0, RSP_VALID cycle 2.
REQ-029 Read 0xA010, cart returns 0x3C -> CS=1 with CART_RD cycles 1-2, RSP_DATA=0x3C cycle 3.
REQ-030 Read 0xC000 -> no CART_RD/WR/CS, RSP_VALID cycle 1, RSP_DATA=0xFF.
REQ-031 REQ_VALID held high for two reads 0x0100, 0x0101 -> second accepted in cycle 4, RSP_VALID in cycles 3 and 7.
REQ-032 rst pulsed in cycle 1 of a read to 0x0150 -> CART_RD=0 next cycle, no RSP_VALID, REQ_READY=1, CART_ADDR=0x0000.
